rom_load_sequencer: RTL
=======================

Name: rom_load_sequencer

Overview:
- Sits between the hps_io ioctl download stream and the arcade core.
- Decodes the flat download address into per-ROM-region write strobes and region-relative addresses, and counts delivered bytes against the expected image size.
- Owns the core reset: holds the core in reset until a valid image is loaded, and stretches user/system reset requests to a guaranteed minimum width.

Parameters:
- R1_BASE, 17'h0C000, first address of region 1; region 0 is [0, R1_BASE).
- R2_BASE, 17'h10000, first address of region 2.
- R3_BASE, 17'h12000, first address of region 3.
- IMG_SIZE, 17'h14000, expected total byte count; region 3 is [R3_BASE, IMG_SIZE).
- RST_CYCLES, 16, minimum core-reset pulse width in clk_sys cycles after any reset cause ends.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dn_download  in  1  download window active.
- dn_wr  in  1  one-cycle byte strobe.
- dn_addr  in  25  byte address.
- dn_data  in  8  byte.
- soft_reset  in  1  level OR of the menu/button/system reset sources.
- rom_we  out  4  one-hot write strobe, bit n = region n.
- rom_addr  out  17  address relative to the region base.
- rom_data  out  8  registered data.
- core_reset  out  1  active-high reset to the core.
- load_ok  out  1  last image complete and clean.
- load_err  out  1  last image bad.
- byte_count  out  17  bytes accepted in the current or last download.

Behaviour:
- Reset values: rom_we=0, rom_addr=0, rom_data=0, core_reset=1, load_ok=0, load_err=0, byte_count=0, state=BOOT, stretch counter=RST_CYCLES.
- Write path: 1-cycle latency. When dn_wr=1 and state=LOAD, the next cycle drives rom_we = one-hot(region), rom_addr = dn_addr minus region base, rom_data = dn_data, and increments byte_count.
- rom_we is 0 in all other cycles; it is never held for more than one cycle per dn_wr.
- Out-of-range write (dn_addr >= IMG_SIZE, including any set bit in [24:17]): no rom_we, byte_count not incremented, sticky bad flag set.
- dn_wr outside LOAD is ignored entirely.
- byte_count saturates at 17'h1FFFF.
- State machine:
  - BOOT: core_reset=1. dn_download rise -> LOAD.
  - LOAD: on entry, byte_count=0, bad flag=0, load_ok=0, load_err=0. core_reset=1. dn_download fall -> CHECK.
  - CHECK: one cycle. If byte_count==IMG_SIZE and bad flag=0, set load_ok=1 and go to STRETCH. Otherwise set load_err=1 and go to ERROR.
  - STRETCH: core_reset=1, counter decrements each cycle. soft_reset=1 reloads the counter to RST_CYCLES. Counter reaching 0 -> RUN.
  - RUN: core_reset=0. soft_reset=1 -> reload counter, go to STRETCH. dn_download rise -> LOAD.
  - ERROR: core_reset=1 permanently. dn_download rise -> LOAD (retry allowed). soft_reset has no effect.
- Edge detection: dn_download is registered once; rise and fall are detected against the registered copy.
- Simultaneous events: dn_download rise takes priority over soft_reset in RUN and STRETCH.
- dn_wr on the same cycle as the dn_download rise is dropped, because LOAD starts the following cycle.
- Reset mid-download: returns to BOOT with the core held in reset. A partial image never releases the core. The host must restart the download.
- core_reset is registered, so it is glitch-free.
- core_reset deassertion requires a full RST_CYCLES window with soft_reset=0.

Decomposition:
- Shared package rom_load_pkg holds:
  - the state enum (BOOT, LOAD, CHECK, STRETCH, RUN, ERROR);
  - the default region bases and IMG_SIZE localparams;
  - a region-decode function returning {region index, valid}.
- One natural sub-module, reset_stretcher: the counter with reload, a done flag, and the soft_reset input. The FSM instantiates it.

Test Plan:
- Clean load: after reset_n release, download bytes 0..0x13FFF in order with gaps between dn_wr. Required:
  - rom_we=4'b0001 for addr 0..0xBFFF;
  - 4'b0010 at 0xC000 with rom_addr=0;
  - 4'b1000 at 0x13FFF with rom_addr=0x1FFF;
  - byte_count=0x14000, load_ok=1;
  - core_reset falls exactly RST_CYCLES+2 cycles after the dn_download fall.
- Short image: download 0x13FFF bytes -> load_err=1, load_ok=0, core_reset stays 1 for 1000 cycles.
- Out-of-range write: full image plus one write at 0x14000 -> no rom_we pulse for that write, byte_count=0x14000, load_err=1.
- Soft reset in RUN: pulse soft_reset for 3 cycles -> core_reset=1 next cycle, released RST_CYCLES cycles after soft_reset falls. A second soft_reset mid-stretch restarts the count.
- Reload: from RUN, raise dn_download -> core_reset=1 next cycle, byte_count clears, load_ok=0. A valid second image returns the core to RUN.
- Async reset mid-LOAD: assert reset_n=0 after 100 bytes. Required:
  - all outputs take their reset values immediately;
  - dn_download falling with no new rise leaves the block in BOOT with core_reset=1.

Source files
------------

// File: rtl/rom_load_pkg.sv
// rom_load_pkg
// Shared definitions for the ROM download sequencer:
//   - load_state_t    : sequencer state encoding
//   - DEF_* params    : default ROM region map, image size and reset width
//   - region_t        : decoded download address {region index, valid}
//   - region_decode() : maps a flat download address onto a ROM region
package rom_load_pkg;

    typedef enum logic [2:0] {
        BOOT,
        LOAD,
        CHECK,
        STRETCH,
        RUN,
        ERROR
    } load_state_t;

    localparam logic [16:0] DEF_R1_BASE    = 17'h0C000;
    localparam logic [16:0] DEF_R2_BASE    = 17'h10000;
    localparam logic [16:0] DEF_R3_BASE    = 17'h12000;
    localparam logic [16:0] DEF_IMG_SIZE   = 17'h14000;
    localparam int          DEF_RST_CYCLES = 16;

    localparam logic [16:0] BYTE_COUNT_MAX = 17'h1FFFF;

    typedef struct packed {
        logic [1:0] idx;
        logic       valid;
    } region_t;

    // An address is valid only if no bit above the 17-bit ROM space is set
    // and it lies below the image size. Regions are tested from the top down
    // so each one is [base, next_base).
    function automatic region_t region_decode(
        input logic [24:0] addr,
        input logic [16:0] r1_base,
        input logic [16:0] r2_base,
        input logic [16:0] r3_base,
        input logic [16:0] img_size
    );
        region_t r;
        r.idx   = 2'd0;
        r.valid = 1'b0;
        if ((addr[24:17] == 8'd0) && (addr[16:0] < img_size)) begin
            r.valid = 1'b1;
            if (addr[16:0] >= r3_base) begin
                r.idx = 2'd3;
            end else if (addr[16:0] >= r2_base) begin
                r.idx = 2'd2;
            end else if (addr[16:0] >= r1_base) begin
                r.idx = 2'd1;
            end else begin
                r.idx = 2'd0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_load_sequencer_reset_stretcher.sv
// reset_stretcher
// Down-counter that guarantees a minimum core-reset width.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset (counter -> RST_CYCLES)
//   reload     in  hold the counter at RST_CYCLES (sequencer not stretching)
//   run        in  count down one per cycle (sequencer in STRETCH)
//   soft_reset in  any reset request; restarts the full window
//   done       out high in the cycle whose edge brings the count to zero
// RST_CYCLES must be at least 1.
module reset_stretcher #(
    parameter int RST_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic run,
    input  logic soft_reset,
    output logic done
);

    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(RST_CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_INIT;
        end else if (reload || soft_reset) begin
            cnt <= CNT_INIT;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Flag the last counting cycle, so the sequencer leaves STRETCH on the
    // same edge the count reaches zero: exactly RST_CYCLES cycles in STRETCH
    // once soft_reset is low.
    assign done = run && !reload && !soft_reset && (cnt <= CW'(1));

endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
// Bridges the hps_io ioctl download stream to the arcade core ROMs and owns
// the core reset.
// Ports:
//   clk_sys     in   system clock, all logic on rising edge
//   reset_n     in   asynchronous active-low reset
//   dn_download in   download window active
//   dn_wr       in   one-cycle byte strobe
//   dn_addr     in   [24:0] flat byte address
//   dn_data     in   [7:0]  byte
//   soft_reset  in   OR of menu/button/system reset requests
//   rom_we      out  [3:0]  one-hot region write strobe (one cycle per byte)
//   rom_addr    out  [16:0] address relative to the region base
//   rom_data    out  [7:0]  registered byte
//   core_reset  out  active-high core reset (registered)
//   load_ok     out  last image complete and clean
//   load_err    out  last image bad
//   byte_count  out  [16:0] bytes accepted in current/last download
// Handshake: dn_wr is a fire-and-forget strobe, there is no backpressure;
// each accepted strobe yields exactly one rom_we pulse one cycle later.
module rom_load_sequencer
    import rom_load_pkg::*;
#(
    parameter logic [16:0] R1_BASE    = DEF_R1_BASE,
    parameter logic [16:0] R2_BASE    = DEF_R2_BASE,
    parameter logic [16:0] R3_BASE    = DEF_R3_BASE,
    parameter logic [16:0] IMG_SIZE   = DEF_IMG_SIZE,
    parameter int          RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [24:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        soft_reset,
    output logic [3:0]  rom_we,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err,
    output logic [16:0] byte_count
);

    load_state_t state;
    load_state_t state_next;

    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;
    logic        bad;
    logic        stretch_done;
    logic        image_good;
    logic        enter_load;
    logic        wr_accept;
    logic        wr_reject;
    region_t     dec;
    logic [16:0] region_base;

    // ------------------------------------------------------------------
    // dn_download edge detection. The registered copy resets high so a
    // download that is still active when reset is released is not taken
    // for a new one; the host must drop and raise dn_download again.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_q <= 1'b1;
        end else begin
            dl_q <= dn_download;
        end
    end

    assign dl_rise = dn_download && !dl_q;
    assign dl_fall = !dn_download && dl_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign dec = region_decode(dn_addr, R1_BASE, R2_BASE, R3_BASE, IMG_SIZE);

    always_comb begin
        region_base = 17'd0;
        case (dec.idx)
            2'd1:    region_base = R1_BASE;
            2'd2:    region_base = R2_BASE;
            2'd3:    region_base = R3_BASE;
            default: region_base = 17'd0;
        endcase
    end

    assign wr_accept = (state == LOAD) && dn_wr && dec.valid;
    assign wr_reject = (state == LOAD) && dn_wr && !dec.valid;

    // ------------------------------------------------------------------
    // Reset stretcher: held at full count outside STRETCH, so every entry
    // into STRETCH starts a complete window.
    // ------------------------------------------------------------------
    reset_stretcher #(
        .RST_CYCLES(RST_CYCLES)
    ) u_stretcher (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .reload    (state != STRETCH),
        .run       (state == STRETCH),
        .soft_reset(soft_reset),
        .done      (stretch_done)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    assign image_good = (byte_count == IMG_SIZE) && !bad;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT: begin
                if (dl_rise) state_next = LOAD;
            end
            LOAD: begin
                if (dl_fall) state_next = CHECK;
            end
            CHECK: begin
                state_next = image_good ? STRETCH : ERROR;
            end
            STRETCH: begin
                // A new download wins over finishing the stretch.
                if (dl_rise) begin
                    state_next = LOAD;
                end else if (stretch_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (dl_rise) begin
                    state_next = LOAD;
                end else if (soft_reset) begin
                    state_next = STRETCH;
                end
            end
            ERROR: begin
                if (dl_rise) state_next = LOAD;
            end
            default: state_next = BOOT;
        endcase
    end

    assign enter_load = (state_next == LOAD) && (state != LOAD);

    // ------------------------------------------------------------------
    // Status, byte counter and core reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_reset <= 1'b1;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
            byte_count <= 17'd0;
            bad        <= 1'b0;
        end else begin
            // Registered from the next state so the core sees a clean level.
            core_reset <= (state_next != RUN);
            if (enter_load) begin
                load_ok    <= 1'b0;
                load_err   <= 1'b0;
                byte_count <= 17'd0;
                bad        <= 1'b0;
            end else begin
                if (wr_accept && (byte_count != BYTE_COUNT_MAX)) begin
                    byte_count <= byte_count + 17'd1;
                end
                if (wr_reject) begin
                    bad <= 1'b1;
                end
                if (state == CHECK) begin
                    if (image_good) begin
                        load_ok <= 1'b1;
                    end else begin
                        load_err <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // ROM write path: one-cycle strobe, address/data hold between writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rom_we   <= 4'd0;
            rom_addr <= 17'd0;
            rom_data <= 8'd0;
        end else begin
            rom_we <= wr_accept ? (4'b0001 << dec.idx) : 4'd0;
            if (wr_accept) begin
                rom_addr <= dn_addr[16:0] - region_base;
                rom_data <= dn_data;
            end
        end
    end

endmodule
